// File: rtl/serv_bufreg_seq.sv
// Phase sequencer for the multi-bit-per-cycle buffer register: walks one operation through
// INIT, optional PRE/BUS, and RUN phases, and owns the word-cycle counter for that datapath.
module serv_bufreg_seq #(
   parameter int unsigned BITS_PER_CYCLE = 8,
   parameter int unsigned LB             = $clog2(BITS_PER_CYCLE)
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_op_valid,
   output logic          o_op_ready,
   input  logic [1:0]    i_op_type,
   input  logic          i_right,
   input  logic [4:0]    i_shamt,
   output logic          o_cnt0,
   output logic          o_cnt1,
   output logic          o_en,
   output logic          o_init,
   output logic          o_shift_op,
   output logic          o_right_shift_op,
   output logic [LB:0]   o_shift_counter_lsb,
   output logic          o_rd_zero,
   output logic          o_dbus_cyc,
   input  logic          i_dbus_ack,
   output logic          o_done
);

   localparam int unsigned W  = 32 / BITS_PER_CYCLE;
   localparam int unsigned CW = 5 - LB;

   typedef enum logic [2:0] {StIdle, StInit, StBus, StPre, StRun} state_e;

   state_e          r_state;
   logic [CW-1:0]   r_cnt;
   logic [1:0]      r_type;
   logic            r_right;
   logic [4:0]      r_shamt;

   logic            w_last;
   logic [CW-1:0]   w_k;

   // W-1 is all ones in a CW-bit counter
   assign w_last = &r_cnt;
   assign w_k    = r_shamt[4:LB];

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= StIdle;
         r_cnt   <= '0;
         r_type  <= 2'b00;
         r_right <= 1'b0;
         r_shamt <= 5'd0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (i_op_valid) begin
                  r_state <= StInit;
                  r_cnt   <= '0;
                  r_type  <= (i_op_type == 2'b11) ? 2'b00 : i_op_type;
                  r_right <= i_right;
                  r_shamt <= i_shamt;
               end
            end
            StInit: begin
               r_cnt <= r_cnt + CW'(1);
               if (w_last) begin
                  case (r_type)
                     2'b01:   r_state <= StBus;
                     2'b10:   r_state <= (r_right && (w_k != '0)) ? StPre : StRun;
                     default: r_state <= StIdle;
                  endcase
               end
            end
            StBus: begin
               if (i_dbus_ack) r_state <= StIdle;
            end
            StPre: begin
               if (r_cnt == w_k - CW'(1)) begin
                  r_state <= StRun;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            StRun: begin
               r_cnt <= r_cnt + CW'(1);
               if (w_last) r_state <= StIdle;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign o_op_ready       = (r_state == StIdle);
   assign o_init           = (r_state == StInit);
   assign o_shift_op       = (r_state == StPre) || (r_state == StRun);
   assign o_en             = o_init || o_shift_op;
   assign o_cnt0           = (r_cnt == '0) && o_en;
   assign o_cnt1           = (r_cnt == CW'(1)) && o_en;
   assign o_right_shift_op = r_right;
   assign o_dbus_cyc       = (r_state == StBus);
   assign o_rd_zero        = (r_state == StRun) && !r_right && (r_cnt < w_k);
   assign o_done           = ((r_state == StInit) && w_last && (r_type == 2'b00)) ||
                             ((r_state == StBus) && i_dbus_ack) ||
                             ((r_state == StRun) && w_last);

   generate
      if (LB == 0) begin : g_no_lsb
         assign o_shift_counter_lsb = 1'b0;
      end else begin : g_lsb
         assign o_shift_counter_lsb = o_shift_op ? {1'b0, r_shamt[LB-1:0]} : '0;
      end
   endgenerate

endmodule

// File: tb/tb_serv_bufreg_seq.sv
// Directed bench for serv_bufreg_seq: a B=8 instance for most phases and a B=4 instance
// for the left-shift case, with hand-computed per-cycle strobe vectors.
module tb_serv_bufreg_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   // B=8 instance
   logic       v8, ack8, r8, ready8, cnt0_8, cnt1_8, en8, init8, sh8, rso8, rdz8, cyc8, done8;
   logic [1:0] t8;
   logic [4:0] s8;
   logic [3:0] lsb8;
   // B=4 instance
   logic       v4, ack4, r4, ready4, cnt0_4, cnt1_4, en4, init4, sh4, rso4, rdz4, cyc4, done4;
   logic [1:0] t4;
   logic [4:0] s4;
   logic [2:0] lsb4;

   int n_err = 0;
   int n_chk = 0;

   // {ready, en, init, cnt0, cnt1, shift_op, rd_zero, cyc, done}
   logic [8:0] st8, st4;
   assign st8 = {ready8, en8, init8, cnt0_8, cnt1_8, sh8, rdz8, cyc8, done8};
   assign st4 = {ready4, en4, init4, cnt0_4, cnt1_4, sh4, rdz4, cyc4, done4};

   serv_bufreg_seq #(.BITS_PER_CYCLE(8)) u_dut8 (
      .i_clk(clk), .i_rst_n(rst_n), .i_op_valid(v8), .o_op_ready(ready8), .i_op_type(t8),
      .i_right(r8), .i_shamt(s8), .o_cnt0(cnt0_8), .o_cnt1(cnt1_8), .o_en(en8),
      .o_init(init8), .o_shift_op(sh8), .o_right_shift_op(rso8), .o_shift_counter_lsb(lsb8),
      .o_rd_zero(rdz8), .o_dbus_cyc(cyc8), .i_dbus_ack(ack8), .o_done(done8)
   );

   serv_bufreg_seq #(.BITS_PER_CYCLE(4)) u_dut4 (
      .i_clk(clk), .i_rst_n(rst_n), .i_op_valid(v4), .o_op_ready(ready4), .i_op_type(t4),
      .i_right(r4), .i_shamt(s4), .o_cnt0(cnt0_4), .o_cnt1(cnt1_4), .o_en(en4),
      .o_init(init4), .o_shift_op(sh4), .o_right_shift_op(rso4), .o_shift_counter_lsb(lsb4),
      .o_rd_zero(rdz4), .o_dbus_cyc(cyc4), .i_dbus_ack(ack4), .o_done(done4)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic c8(input string tag, input logic [8:0] exp);
      chk(tag, {23'd0, st8}, {23'd0, exp});
   endtask

   task automatic c4(input string tag, input logic [8:0] exp);
      chk(tag, {23'd0, st4}, {23'd0, exp});
   endtask

   task automatic step8(input string tag, input logic [8:0] exp);
      @(negedge clk);
      #1;
      c8(tag, exp);
   endtask

   task automatic step4(input string tag, input logic [8:0] exp);
      @(negedge clk);
      #1;
      c4(tag, exp);
   endtask

   initial begin
      rst_n = 1'b0;
      v8 = 0; t8 = 0; r8 = 0; s8 = 0; ack8 = 0;
      v4 = 0; t4 = 0; r4 = 0; s4 = 0; ack4 = 0;
      repeat (2) @(negedge clk);
      #1;
      c8("rst_st8", 9'h100);
      chk("rst_lsb8", {28'd0, lsb8}, 32'd0);
      chk("rst_rso8", {31'd0, rso8}, 32'd0);
      c4("rst_st4", 9'h100);
      rst_n = 1'b1;

      // ALU op: INIT cycles 1-4, done in 4, ready in 5
      @(negedge clk); v8 = 1; t8 = 2'b00; #1; c8("alu_xfer", 9'h100);
      @(negedge clk); v8 = 0; #1; c8("alu_c1", 9'h0E0);
      step8("alu_c2", 9'h0D0);
      step8("alu_c3", 9'h0C0);
      step8("alu_c4_done", 9'h0C1);
      step8("alu_c5_ready", 9'h100);

      // Memory op: BUS cycles 5-8, ack in 8
      @(negedge clk); v8 = 1; t8 = 2'b01; #1; c8("mem_xfer", 9'h100);
      @(negedge clk); v8 = 0; #1; c8("mem_c1", 9'h0E0);
      step8("mem_c2", 9'h0D0);
      step8("mem_c3", 9'h0C0);
      step8("mem_c4", 9'h0C0);
      step8("mem_c5", 9'h002);
      step8("mem_c6", 9'h002);
      step8("mem_c7", 9'h002);
      @(negedge clk); ack8 = 1; #1; c8("mem_c8_ack", 9'h003);
      @(negedge clk); ack8 = 0; #1; c8("mem_c9", 9'h100);

      // Right shift, shamt=13: k=1, lsb=5
      @(negedge clk); v8 = 1; t8 = 2'b10; r8 = 1; s8 = 5'd13; #1; c8("rsh_xfer", 9'h100);
      @(negedge clk); v8 = 0; #1; c8("rsh_c1", 9'h0E0);
      chk("rsh_rso", {31'd0, rso8}, 32'd1);
      chk("rsh_lsb_init", {28'd0, lsb8}, 32'd0);
      step8("rsh_c2", 9'h0D0);
      step8("rsh_c3", 9'h0C0);
      step8("rsh_c4", 9'h0C0);
      step8("rsh_c5_pre", 9'h0A8);
      chk("rsh_lsb_pre", {28'd0, lsb8}, 32'd5);
      step8("rsh_c6", 9'h0A8);
      step8("rsh_c7", 9'h098);
      step8("rsh_c8", 9'h088);
      step8("rsh_c9_done", 9'h089);
      chk("rsh_lsb_run", {28'd0, lsb8}, 32'd5);
      step8("rsh_c10", 9'h100);
      chk("rsh_lsb_idle", {28'd0, lsb8}, 32'd0);

      // Right shift, shamt=3: k=0, no PRE phase
      @(negedge clk); v8 = 1; t8 = 2'b10; r8 = 1; s8 = 5'd3; #1; c8("rk0_xfer", 9'h100);
      @(negedge clk); v8 = 0; #1; c8("rk0_c1", 9'h0E0);
      repeat (3) @(negedge clk);
      step8("rk0_c5_run", 9'h0A8);
      chk("rk0_lsb", {28'd0, lsb8}, 32'd3);
      step8("rk0_c6", 9'h098);
      step8("rk0_c7", 9'h088);
      step8("rk0_c8_done", 9'h089);
      step8("rk0_c9", 9'h100);

      // B=4 left shift, shamt=9: k=2, lsb=1, RUN cycles 9-16
      @(negedge clk); v4 = 1; t4 = 2'b10; r4 = 0; s4 = 5'd9; #1; c4("lsh_xfer", 9'h100);
      @(negedge clk); v4 = 0; #1; c4("lsh_c1", 9'h0E0);
      step4("lsh_c2", 9'h0D0);
      for (int i = 0; i < 6; i++) step4("lsh_init", 9'h0C0);
      step4("lsh_c9", 9'h0AC);
      chk("lsh_lsb", {29'd0, lsb4}, 32'd1);
      chk("lsh_rso", {31'd0, rso4}, 32'd0);
      step4("lsh_c10", 9'h09C);
      for (int i = 0; i < 5; i++) step4("lsh_run", 9'h088);
      step4("lsh_c16_done", 9'h089);
      step4("lsh_c17", 9'h100);

      // Reset during the second BUS cycle, then an ALU op
      @(negedge clk); v8 = 1; t8 = 2'b01; r8 = 0; s8 = 0; #1; c8("rb_xfer", 9'h100);
      @(negedge clk); v8 = 0; #1; c8("rb_c1", 9'h0E0);
      repeat (3) @(negedge clk);
      step8("rb_c5", 9'h002);
      @(negedge clk); rst_n = 0; #1; c8("rb_c6", 9'h002);
      @(negedge clk); rst_n = 1; #1; c8("rb_c7_idle", 9'h100);
      @(negedge clk); v8 = 1; t8 = 2'b00; #1; c8("rb_alu_xfer", 9'h100);
      @(negedge clk); v8 = 0; #1; c8("rb_alu_c1", 9'h0E0);
      repeat (2) @(negedge clk);
      step8("rb_alu_done", 9'h0C1);

      // Valid held high; stray ack in INIT; type 11 behaves as 00
      @(negedge clk); v8 = 1; t8 = 2'b00; #1; c8("bb_x0", 9'h100);
      @(negedge clk); ack8 = 1; #1; c8("bb_c1_ack", 9'h0E0);
      @(negedge clk); ack8 = 0; #1; c8("bb_c2", 9'h0D0);
      step8("bb_c3", 9'h0C0);
      step8("bb_c4_done", 9'h0C1);
      @(negedge clk); t8 = 2'b11; #1; c8("bb_x5", 9'h100);
      step8("bb_c6", 9'h0E0);
      repeat (2) @(negedge clk);
      step8("bb_c9_done", 9'h0C1);
      @(negedge clk); v8 = 0; #1; c8("bb_x10", 9'h100);
      step8("bb_c11_idle", 9'h100);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/serv_bufreg_seq.md
# serv_bufreg_seq

Phase sequencer for the multi-bit-per-cycle buffer register. It accepts one operation at a time from the decoder (address compute, memory access or shift) and walks the buffer register through its phases. It drives the phase strobes (cnt0/cnt1/en/init), the sub-word shift amount and the data-bus request, then reports completion. It sits between the decoder/state logic and the buffer register, and owns the word-cycle counter for that datapath.

## Interface
- BITS_PER_CYCLE, 8, datapath width per cycle; legal values 1, 4, 8
- LB, $clog2(BITS_PER_CYCLE), width of the sub-word shift field
- i_clk  in  1  clock; all state updates on the rising edge
- i_rst_n  in  1  reset, synchronous, active-low
- i_op_valid  in  1  operation request
- o_op_ready  out  1  high only in IDLE; transfer occurs when valid & ready
- i_op_type  in  2  00 = address/ALU, 01 = memory, 10 = shift; 11 is treated as 00
- i_right  in  1  shift direction, right when 1; sampled at transfer
- i_shamt  in  5  shift amount; sampled at transfer
- o_cnt0  out  1  first cycle of a word phase
- o_cnt1  out  1  second cycle of a word phase
- o_en  out  1  buffer register enable
- o_init  out  1  load phase (rs1 + imm accumulate)
- o_shift_op  out  1  shift phase active
- o_right_shift_op  out  1  registered copy of i_right
- o_shift_counter_lsb  out  LB+1  {1'b0, shamt[LB-1:0]}; all zero when LB = 0
- o_rd_zero  out  1  consumer writes zeros instead of o_q
- o_dbus_cyc  out  1  data-bus request
- i_dbus_ack  in  1  data-bus acknowledge
- o_done  out  1  one-cycle completion pulse

## Operation
- W = 32/BITS_PER_CYCLE cycles per word. Word counter cnt runs 0..W-1 and wraps to 0.
- o_cnt0 = (cnt == 0) & o_en. o_cnt1 = (cnt == 1) & o_en.
- Latched at transfer: type, right, shamt. k = shamt[4:LB] is the word-level shift count (0..W-1).
- States:
  - IDLE: ready = 1, en = 0. On transfer, go to INIT with cnt = 0.
  - INIT: en = 1, init = 1 for W cycles. On the last cycle (cnt = W-1):
    - type 00: assert done, go to IDLE.
    - type 01: go to BUS.
    - type 10, right with k > 0: go to PRE.
    - type 10 otherwise: go to RUN.
  - BUS: cyc = 1, en = 0, so the address stays held. On i_dbus_ack, assert done in the same cycle; cyc drops next cycle and state goes to IDLE.
  - PRE: en = 1, init = 0, shift_op = 1 for k cycles. These cycles drain low words; o_q is discarded. Then go to RUN with cnt = 0.
  - RUN: en = 1, shift_op = 1 for W cycles. For a left shift, o_rd_zero = 1 while cnt < k. Assert done on the last cycle (cnt = W-1), then go to IDLE.
- o_shift_counter_lsb:
  - held stable from transfer until done;
  - forced to 0 when shift_op is low.
- i_dbus_ack outside BUS is ignored. i_op_valid outside IDLE is ignored; no queueing.

## Timing
- Reset values: all outputs 0 except o_op_ready = 1. State = IDLE, cnt = 0.
- Reset asserted mid-operation:
  - next edge returns to IDLE;
  - o_dbus_cyc drops without waiting for ack;
  - no done pulse.
- Transfer cycle: outputs are still IDLE values. o_en/o_init rise on the following cycle.
- Phases are back-to-back with no bubble cycles between INIT, PRE and RUN.
- Total latency, transfer to done cycle inclusive:
  - type 00: W
  - memory: W + (cycles to ack, minimum 1)
  - right shift: 2W + k
  - left shift: 2W
- o_op_ready returns high the cycle after done. A new op may transfer in that cycle.
- BITS_PER_CYCLE = 1: W = 32, k = shamt, o_shift_counter_lsb is constant 0.

## Test plan
- B=8, type 00, transfer at cycle 0:
  - en = init = 1 in cycles 1-4;
  - cnt0 in cycle 1, cnt1 in cycle 2;
  - done in cycle 4, ready in cycle 5.
- B=8, memory op, ack held low 3 cycles after INIT:
  - cyc high cycles 5-8, en low throughout BUS;
  - done coincides with ack in cycle 8, cyc low in cycle 9.
- B=8, right shift, shamt = 13:
  - k = 1, o_shift_counter_lsb = 5, right_shift_op = 1;
  - PRE in cycle 5, RUN in cycles 6-9, done in cycle 9.
- B=4, left shift, shamt = 9:
  - k = 2, lsb = 1;
  - RUN spans 8 cycles, rd_zero high for the first 2 RUN cycles, done after 16 cycles total.
- Reset asserted in the second BUS cycle:
  - next cycle: cyc = 0, ready = 1, no done;
  - a following type 00 op completes in W cycles.
- i_op_valid held high continuously with ops of type 00:
  - exactly one transfer per W+1 cycles;
  - a stray i_dbus_ack during INIT causes no state change.
